// File: rtl/lrn_window_engine_if.sv
// Signal bundle between the LRN window engine, the GLB read path and the divider.
// The engine takes the slave side; the driving environment takes the master side.
interface lrn_window_engine_if #(
    parameter int M_WIDTH    = 10,
    parameter int DATA_WIDTH = 16,
    parameter int SUM_W      = 2 * DATA_WIDTH + 3
);
    logic                  start_normalization;
    logic [M_WIDTH-1:0]    dim3;
    logic                  r_enable;
    logic [DATA_WIDTH-1:0] glb_rdata;
    logic                  div_in_ready;
    logic                  div_out_valid;
    logic                  full_flag;
    logic                  div_in_valid;
    logic [DATA_WIDTH-1:0] div_num;
    logic [SUM_W-1:0]      div_den;
    logic                  normalized_window;

    modport master (
        output start_normalization, dim3, r_enable, glb_rdata, div_in_ready, div_out_valid,
        input  full_flag, div_in_valid, div_num, div_den, normalized_window
    );

    modport slave (
        input  start_normalization, dim3, r_enable, glb_rdata, div_in_ready, div_out_valid,
        output full_flag, div_in_valid, div_num, div_den, normalized_window
    );
endinterface

// File: rtl/lrn_window_engine.sv
// LRN window engine: buffers one channel column from GLB, forms each channel's windowed
// sum of squares, hands (numerator, denominator) pairs to the divider and tracks returns.
module lrn_window_engine #(
    parameter int M_WIDTH     = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_CH      = 64,
    parameter int LOCAL_SIZE  = 5,
    parameter int ALPHA       = 1,
    parameter int ALPHA_SHIFT = 0,
    parameter int K_CONST     = 2
) (
    input  logic              core_clk,
    input  logic              reset,
    lrn_window_engine_if.slave eng
);
    localparam int SUM_W  = 2 * DATA_WIDTH + 3;
    localparam int PROD_W = SUM_W + 34;
    localparam int IDX_W  = $clog2(MAX_CH);
    localparam int H      = LOCAL_SIZE / 2;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ACCUM, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  rd_valid_q;
    logic [M_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [M_WIDTH-1:0]    dim3_q, dim3_d;
    logic [M_WIDTH-1:0]    c_q, c_d;
    logic [M_WIDTH-1:0]    k_q, k_d;
    logic [M_WIDTH-1:0]    res_cnt_q, res_cnt_d;
    logic                  full_q, full_d;
    logic [SUM_W-1:0]      acc_q;
    logic [DATA_WIDTH-1:0] buf_q [MAX_CH];

    logic                  acc_clr, acc_add, cap_en, cnt_inc;
    logic [IDX_W-1:0]      cap_addr;
    logic [DATA_WIDTH-1:0] k_word;
    logic [2*DATA_WIDTH-1:0] sq;

    function automatic logic [M_WIDTH-1:0] win_lo(input logic [M_WIDTH-1:0] c);
        if (c >= M_WIDTH'(H)) return c - M_WIDTH'(H);
        return '0;
    endfunction

    function automatic logic [M_WIDTH-1:0] win_hi(input logic [M_WIDTH-1:0] c,
                                                  input logic [M_WIDTH-1:0] d);
        logic [M_WIDTH:0]   s;
        logic [M_WIDTH-1:0] last;
        last = d - M_WIDTH'(1);
        s    = {1'b0, c} + (M_WIDTH+1)'(H);
        if (s > {1'b0, last}) return last;
        return s[M_WIDTH-1:0];
    endfunction

    // Wide intermediate so the ALPHA product cannot wrap before the saturation test.
    function automatic logic [SUM_W-1:0] scale_sat(input logic [SUM_W-1:0] s);
        logic [PROD_W-1:0] p;
        p = PROD_W'(s) * PROD_W'(ALPHA);
        p = p >> ALPHA_SHIFT;
        p = p + PROD_W'(K_CONST);
        if (|p[PROD_W-1:SUM_W]) return '1;
        return p[SUM_W-1:0];
    endfunction

    assign k_word = buf_q[k_q[IDX_W-1:0]];
    assign sq     = k_word * k_word;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        dim3_d    = dim3_q;
        c_d       = c_q;
        k_d       = k_q;
        full_d    = full_q;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        cap_en    = 1'b0;
        cap_addr  = wr_ptr_q[IDX_W-1:0];
        cnt_inc   = eng.div_out_valid &&
                    (state_q == S_ACCUM || state_q == S_ISSUE || state_q == S_DRAIN);
        res_cnt_d = res_cnt_q + M_WIDTH'(cnt_inc);

        unique case (state_q)
            S_IDLE: begin
                if (eng.start_normalization && eng.dim3 != '0) begin
                    state_d  = S_FILL;
                    wr_ptr_d = '0;
                    dim3_d   = eng.dim3;
                end
            end
            S_FILL: begin
                if (rd_valid_q) begin
                    cap_en   = ({1'b0, wr_ptr_q} < (M_WIDTH+1)'(MAX_CH));
                    wr_ptr_d = wr_ptr_q + M_WIDTH'(1);
                    if (wr_ptr_q == dim3_q - M_WIDTH'(1)) begin
                        full_d    = 1'b1;
                        wr_ptr_d  = '0;
                        c_d       = '0;
                        k_d       = '0;
                        acc_clr   = 1'b1;
                        res_cnt_d = '0;
                        state_d   = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                acc_add = 1'b1;
                k_d     = k_q + M_WIDTH'(1);
                if (k_q >= win_hi(c_q, dim3_q)) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (eng.div_in_ready) begin
                    if (c_q == dim3_q - M_WIDTH'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        c_d     = c_q + M_WIDTH'(1);
                        k_d     = win_lo(c_q + M_WIDTH'(1));
                        acc_clr = 1'b1;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_DRAIN: begin
                // Looking at the updated count lets the final pulse release DONE one cycle sooner.
                if (res_cnt_d == dim3_q) state_d = S_DONE;
            end
            S_DONE: begin
                if (eng.start_normalization) begin
                    full_d   = 1'b0;
                    wr_ptr_d = '0;
                    if (eng.dim3 != '0) begin
                        dim3_d  = eng.dim3;
                        state_d = S_FILL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (rd_valid_q) begin
                    full_d   = 1'b0;
                    cap_en   = 1'b1;
                    cap_addr = '0;
                    wr_ptr_d = M_WIDTH'(1);
                    state_d  = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rd_valid_q <= 1'b0;
            wr_ptr_q   <= '0;
            dim3_q     <= '0;
            c_q        <= '0;
            k_q        <= '0;
            res_cnt_q  <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= eng.r_enable;
            wr_ptr_q   <= wr_ptr_d;
            dim3_q     <= dim3_d;
            c_q        <= c_d;
            k_q        <= k_d;
            res_cnt_q  <= res_cnt_d;
            full_q     <= full_d;
        end
    end

    always_ff @(posedge core_clk) begin
        if (cap_en) buf_q[cap_addr] <= eng.glb_rdata;
        if (acc_clr) acc_q <= '0;
        else if (acc_add) acc_q <= acc_q + SUM_W'(sq);
    end

    assign eng.full_flag         = full_q;
    assign eng.normalized_window = (state_q == S_DONE);
    assign eng.div_in_valid      = (state_q == S_ISSUE);
    assign eng.div_num           = (state_q == S_ISSUE) ? buf_q[c_q[IDX_W-1:0]] : '0;
    assign eng.div_den           = (state_q == S_ISSUE) ? scale_sat(acc_q) : '0;
endmodule
